axi_burst_master: RTL
=====================

# axi_burst_master

Initiator-side AXI4 burst engine: accepts single read or write commands from a core or DMA client, issues one INCR burst on an AXI master port, and streams beat data between the client and the bus. It is the counterpart of the AXI-to-RAM slave bridge. It sits between a processor-side request port and the interconnect. Exactly one transaction is outstanding at a time.

## Interface
Parameters:
- ID_W_WIDTH, 4, AWID/BID width
- ID_R_WIDTH, 4, ARID/RID width
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data bus width; multiple of 8, at least 8

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- axi_m  axi_if.m  -  AXI master port: AW, W, B, AR and R channels
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_write  in  1  1 selects write, 0 selects read
- cmd_addr  in  ADDR_WIDTH  start byte address
- cmd_len  in  8  beats minus 1 (AXI LEN encoding)
- cmd_id  in  max(ID_W_WIDTH, ID_R_WIDTH)  transaction ID; LSBs are used per channel
- wr_valid / wr_ready  in / out  1  write-data stream handshake
- wr_data  in  DATA_WIDTH  write beat data
- wr_strb  in  DATA_WIDTH/8  write byte enables
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read beat data
- rd_last  out  1  final beat of the read burst
- done  out  1  one-cycle pulse when a transaction completes
- done_err  out  1  protocol error flag, valid while done is high

## Operation
- States: IDLE, ADDR_R, DATA_R, ADDR_W, DATA_W, RESP_B, DONE.
- IDLE: cmd_ready=1. On accept, latch addr, len, id and write. Next state is ADDR_W if write, otherwise ADDR_R. Clear the beat counter and the error flag.
- ADDR_R / ADDR_W:
  - ARVALID/AWVALID=1 with the latched ADDR, LEN and ID; SIZE=$clog2(DATA_WIDTH/8); BURST=2'b01.
  - All A-channel fields are held stable until READY.
  - On READY, go to DATA_R or DATA_W.
- DATA_R:
  - Combinational pass-through: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA.
  - rd_last=1 when beat counter equals latched len.
  - On each R handshake the counter increments.
  - Set the error flag if RLAST does not match (counter==len), or if RID does not equal the latched ID.
  - The handshake at counter==len leads to DONE.
- DATA_W:
  - Combinational pass-through: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WSTRB=wr_strb.
  - WLAST=(counter==len).
  - The handshake at the last beat leads to RESP_B.
- RESP_B: BREADY=1. On BVALID, set the error flag if BID does not match the latched ID, then go to DONE.
- DONE: done=1 and done_err=flag for exactly one cycle, then return to IDLE.
- Outside their own states, all AXI VALID/READY outputs are 0, and so are wr_ready, rd_valid and rd_last.
- RRESP/BRESP are ignored.
- Beat counter width is 8 bits.
  - Counter wrap cannot occur because len is at most 255.
  - Address is not modified by the master; the slave increments it.

## Timing
- While rst is high, every output is 0: cmd_ready, all AXI VALID/READY, wr_ready, rd_valid, rd_last, done and done_err. AXI payload outputs are also 0.
- After rst deasserts, the state is IDLE and cmd_ready=1 on the first cycle.
- Command accept at edge N gives ARVALID or AWVALID high from cycle N+1.
- Minimum turnaround is one cycle each for cmd, A-channel, each beat, B (writes only) and DONE:
  - read: len+4 cycles from accept to return to IDLE
  - write: len+5 cycles from accept to return to IDLE
- Data channels add zero extra latency because they are combinational pass-throughs. Backpressure on either side stalls without data loss.
- A new command can be accepted in the cycle after done.
- rst asserted mid-burst: the block returns to IDLE immediately and VALIDs drop asynchronously. No done pulse is produced. The slave must be reset together with the master.

## Test plan
- Single-beat read: cmd addr=0x0010, len=0, id=3. Slave returns RDATA=0xDEADBEEF with RLAST=1 and RID=3. Expect ARLEN=0, ARSIZE=2, ARBURST=1, rd_last=1 and rd_data=0xDEADBEEF, then done=1 with done_err=0.
- 4-beat write, addr=0x0100, len=3, strb=0xF. Client stalls wr_valid for 2 cycles before beat 2. Expect WLAST only on beat 4, data in order, BREADY after the last beat, and done on the cycle after BVALID.
- Read with rd_ready toggling every other cycle, len=7. Expect exactly 8 rd handshakes, no duplicate or dropped beats, and RREADY mirroring rd_ready.
- Protocol errors:
  - Read case: slave asserts RLAST on beat 2 of a len=3 burst. Expect done_err=1 at done.
  - Write case: BID=5 against command id=2. Expect done_err=1.
- Reset mid-write after 2 of 4 beats: expect AWVALID, WVALID, done and cmd_ready=0 during rst. After release, cmd_ready=1 and a new read completes correctly.
- Back-to-back commands: a write (len=1) then a read (len=1), with cmd_valid held high. Expect the second accept on the cycle after the first done, with no overlap of AW and AR activity.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle shared by the burst master and its slave.
// Five channels; m is the initiator view, s the target view.
interface axi_if #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  logic [ID_W_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_W_WIDTH-1:0]   bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_R_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_R_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator.
// Client data streams pass straight through to W and R.
module axi_burst_master #(
  parameter int ID_W_WIDTH = 4,
  parameter int ID_R_WIDTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_if.m                        axi_m,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [((ID_W_WIDTH > ID_R_WIDTH) ?
                 ID_W_WIDTH : ID_R_WIDTH)-1:0] cmd_id,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic                    done_err
);

  localparam int IDW =
    (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_R,
    S_DATA_R,
    S_ADDR_W,
    S_DATA_W,
    S_RESP_B,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [IDW-1:0]        id_q;
  logic                  err_q;

  logic last_beat;
  logic accept;
  logic r_hs;
  logic w_hs;
  logic r_bad;
  logic b_bad;
  logic unused_resp;

  assign last_beat = (cnt_q == len_q);
  assign accept = (state_q == S_IDLE) && cmd_valid && !rst;
  assign r_hs = (state_q == S_DATA_R) && axi_m.rvalid && rd_ready;
  assign w_hs = (state_q == S_DATA_W) && wr_valid && axi_m.wready;
  assign r_bad = (axi_m.rlast != last_beat) ||
                 (axi_m.rid != id_q[ID_R_WIDTH-1:0]);
  assign b_bad = (axi_m.bid != id_q[ID_W_WIDTH-1:0]);
  assign unused_resp = ^{axi_m.rresp, axi_m.bresp};

  // State register; reset drops every VALID at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Command latch, beat counter and sticky protocol-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
      id_q   <= cmd_id;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (r_hs) begin
      cnt_q <= cnt_q + 8'd1;
      if (r_bad) err_q <= 1'b1;
    end else if (w_hs) begin
      cnt_q <= cnt_q + 8'd1;
    end else if (state_q == S_RESP_B &&
                 axi_m.bvalid && b_bad) begin
      err_q <= 1'b1;
    end
  end

  // Next state and all outputs, zero outside the owning state.
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_data       = '0;
    rd_last       = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    axi_m.awid    = '0;
    axi_m.awaddr  = '0;
    axi_m.awlen   = '0;
    axi_m.awsize  = '0;
    axi_m.awburst = '0;
    axi_m.awvalid = 1'b0;
    axi_m.wdata   = '0;
    axi_m.wstrb   = '0;
    axi_m.wlast   = 1'b0;
    axi_m.wvalid  = 1'b0;
    axi_m.bready  = 1'b0;
    axi_m.arid    = '0;
    axi_m.araddr  = '0;
    axi_m.arlen   = '0;
    axi_m.arsize  = '0;
    axi_m.arburst = '0;
    axi_m.arvalid = 1'b0;
    axi_m.rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = !rst;
        if (accept)
          state_d = cmd_write ? S_ADDR_W : S_ADDR_R;
      end
      S_ADDR_R: begin
        axi_m.arvalid = 1'b1;
        axi_m.araddr  = addr_q;
        axi_m.arlen   = len_q;
        axi_m.arid    = id_q[ID_R_WIDTH-1:0];
        axi_m.arsize  = SIZE;
        axi_m.arburst = 2'b01;
        if (axi_m.arready) state_d = S_DATA_R;
      end
      S_DATA_R: begin
        axi_m.rready = rd_ready;
        rd_valid     = axi_m.rvalid;
        rd_data      = axi_m.rdata;
        rd_last      = last_beat;
        if (r_hs && last_beat) state_d = S_DONE;
      end
      S_ADDR_W: begin
        axi_m.awvalid = 1'b1;
        axi_m.awaddr  = addr_q;
        axi_m.awlen   = len_q;
        axi_m.awid    = id_q[ID_W_WIDTH-1:0];
        axi_m.awsize  = SIZE;
        axi_m.awburst = 2'b01;
        if (axi_m.awready) state_d = S_DATA_W;
      end
      S_DATA_W: begin
        axi_m.wvalid = wr_valid;
        wr_ready     = axi_m.wready;
        axi_m.wdata  = wr_data;
        axi_m.wstrb  = wr_strb;
        axi_m.wlast  = last_beat;
        if (w_hs && last_beat) state_d = S_RESP_B;
      end
      S_RESP_B: begin
        axi_m.bready = 1'b1;
        if (axi_m.bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        done_err = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
